// File: rtl/traffic_light_pkg.sv
// rtl/traffic_light_pkg.sv - shared types and constants for the traffic light controller
package traffic_light_pkg;

    localparam int TIME_W = 10;

    localparam int DEF_TICK_DIV          = 50_000_000;
    localparam int DEF_NORTH_GREEN_TIME  = 30;
    localparam int DEF_NORTH_YELLOW_TIME = 3;
    localparam int DEF_WEST_GREEN_TIME   = 20;
    localparam int DEF_WEST_YELLOW_TIME  = 3;

    typedef enum logic [1:0] {
        NG = 2'd0,
        NY = 2'd1,
        WG = 2'd2,
        WY = 2'd3
    } phase_t;

    typedef struct packed {
        logic n_red;
        logic n_yellow;
        logic n_green;
        logic w_red;
        logic w_yellow;
        logic w_green;
    } lamps_t;

    function automatic phase_t next_phase(input phase_t p);
        case (p)
            NG:      return NY;
            NY:      return WG;
            WG:      return WY;
            WY:      return NG;
            default: return NG;
        endcase
    endfunction

    // The red lamp of each direction covers both phases owned by the other road.
    function automatic lamps_t phase_lamps(input phase_t p);
        lamps_t l;
        l = '0;
        case (p)
            NG: begin l.n_green  = 1'b1; l.w_red    = 1'b1; end
            NY: begin l.n_yellow = 1'b1; l.w_red    = 1'b1; end
            WG: begin l.n_red    = 1'b1; l.w_green  = 1'b1; end
            WY: begin l.n_red    = 1'b1; l.w_yellow = 1'b1; end
            default: begin l.n_green = 1'b1; l.w_red = 1'b1; end
        endcase
        return l;
    endfunction

endpackage

// File: rtl/traffic_light_tick_gen.sv
// rtl/traffic_light_tick_gen.sv - prescaler producing a one-cycle tick every TICK_DIV clocks
module tick_gen #(
    parameter int TICK_DIV = 50_000_000
) (
    input  logic clk,
    input  logic rst_n,
    output logic tick
);

    // A one-cycle divider still needs a 1-bit counter; it simply stays at zero.
    localparam int CNT_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(TICK_DIV - 1);

    logic [CNT_W-1:0] div_cnt;

    always_ff @(posedge clk) begin
        if (rst_n) begin
            div_cnt <= '0;
        end else if (div_cnt == LAST) begin
            div_cnt <= '0;
        end else begin
            div_cnt <= div_cnt + 1'b1;
        end
    end

    assign tick = (div_cnt == LAST);

endmodule

// File: rtl/traffic_light_top.sv
// rtl/traffic_light_top.sv - fixed-time four-phase north/west traffic light controller
module traffic_light_top
    import traffic_light_pkg::*;
#(
    parameter int TICK_DIV          = DEF_TICK_DIV,
    parameter int NORTH_GREEN_TIME  = DEF_NORTH_GREEN_TIME,
    parameter int NORTH_YELLOW_TIME = DEF_NORTH_YELLOW_TIME,
    parameter int WEST_GREEN_TIME   = DEF_WEST_GREEN_TIME,
    parameter int WEST_YELLOW_TIME  = DEF_WEST_YELLOW_TIME
) (
    input  logic clk,
    input  logic rst_n,
    output logic north_red_led,
    output logic north_green_led,
    output logic north_yellow_led,
    output logic west_red_led,
    output logic west_green_led,
    output logic west_yellow_led
);

    localparam logic [TIME_W-1:0] NG_LOAD = TIME_W'(NORTH_GREEN_TIME - 1);
    localparam logic [TIME_W-1:0] NY_LOAD = TIME_W'(NORTH_YELLOW_TIME - 1);
    localparam logic [TIME_W-1:0] WG_LOAD = TIME_W'(WEST_GREEN_TIME - 1);
    localparam logic [TIME_W-1:0] WY_LOAD = TIME_W'(WEST_YELLOW_TIME - 1);

    logic              tick;
    phase_t            state;
    phase_t            state_nxt;
    logic [TIME_W-1:0] sec_cnt;
    lamps_t            lamps;

    function automatic logic [TIME_W-1:0] phase_load(input phase_t p);
        case (p)
            NG:      return NG_LOAD;
            NY:      return NY_LOAD;
            WG:      return WG_LOAD;
            WY:      return WY_LOAD;
            default: return NG_LOAD;
        endcase
    endfunction

    tick_gen #(
        .TICK_DIV (TICK_DIV)
    ) u_tick_gen (
        .clk   (clk),
        .rst_n (rst_n),
        .tick  (tick)
    );

    assign state_nxt = next_phase(state);

    // Lamps are registered alongside the state so they switch on the same edge.
    always_ff @(posedge clk) begin
        if (rst_n) begin
            state   <= NG;
            sec_cnt <= NG_LOAD;
            lamps   <= phase_lamps(NG);
        end else if (tick) begin
            if (sec_cnt == '0) begin
                state   <= state_nxt;
                sec_cnt <= phase_load(state_nxt);
                lamps   <= phase_lamps(state_nxt);
            end else begin
                sec_cnt <= sec_cnt - 1'b1;
                lamps   <= phase_lamps(state);
            end
        end else begin
            lamps <= phase_lamps(state);
        end
    end

    assign north_red_led    = lamps.n_red;
    assign north_yellow_led = lamps.n_yellow;
    assign north_green_led  = lamps.n_green;
    assign west_red_led     = lamps.w_red;
    assign west_yellow_led  = lamps.w_yellow;
    assign west_green_led   = lamps.w_green;

endmodule

// File: tb/tb_traffic_light_top.sv
// tb/tb_traffic_light_top.sv - directed self-checking bench for traffic_light_top
module tb_traffic_light_top;

    logic clk = 1'b0;
    logic rst = 1'b1;

    logic a_nr, a_ny, a_ng, a_wr, a_wy, a_wg;
    logic b_nr, b_ny, b_ng, b_wr, b_wy, b_wg;

    int n_compared   = 0;
    int n_mismatched = 0;

    logic prev_nr, prev_wr;
    int   run_nr, run_wr;
    bit   valid_nr, valid_wr;

    always #10 clk = ~clk;

    traffic_light_top #(
        .TICK_DIV(4), .NORTH_GREEN_TIME(3), .NORTH_YELLOW_TIME(1),
        .WEST_GREEN_TIME(2), .WEST_YELLOW_TIME(1)
    ) dut_a (
        .clk(clk), .rst_n(rst),
        .north_red_led(a_nr), .north_green_led(a_ng), .north_yellow_led(a_ny),
        .west_red_led(a_wr), .west_green_led(a_wg), .west_yellow_led(a_wy)
    );

    traffic_light_top #(
        .TICK_DIV(1), .NORTH_GREEN_TIME(1), .NORTH_YELLOW_TIME(1),
        .WEST_GREEN_TIME(1), .WEST_YELLOW_TIME(1)
    ) dut_b (
        .clk(clk), .rst_n(rst),
        .north_red_led(b_nr), .north_green_led(b_ng), .north_yellow_led(b_ny),
        .west_red_led(b_wr), .west_green_led(b_wg), .west_yellow_led(b_wy)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_compared++;
        if (got !== exp) begin
            n_mismatched++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // {n_red, n_yellow, n_green, w_red, w_yellow, w_green}
    function automatic logic [5:0] exp_lamps(input int ph);
        case (ph)
            0:       return 6'b001_100;
            1:       return 6'b010_100;
            2:       return 6'b100_001;
            default: return 6'b100_010;
        endcase
    endfunction

    function automatic int phase_a(input int c);
        int m;
        m = c % 28;
        if (m < 12) return 0;
        if (m < 16) return 1;
        if (m < 24) return 2;
        return 3;
    endfunction

    task automatic sample(input int c, input bit fresh);
        logic [5:0] la, lb;
        la = {a_nr, a_ny, a_ng, a_wr, a_wy, a_wg};
        lb = {b_nr, b_ny, b_ng, b_wr, b_wy, b_wg};
        check_eq($sformatf("a_lamps c=%0d", c), la, exp_lamps(phase_a(c)));
        check_eq($sformatf("b_lamps c=%0d", c), lb, exp_lamps(c % 4));
        check_eq("a_north_onehot", $countones(la[5:3]), 1);
        check_eq("a_west_onehot", $countones(la[2:0]), 1);
        check_eq("a_safety", {31'd0, (!a_nr && !a_wr)}, 0);
        check_eq("b_safety", {31'd0, (!b_nr && !b_wr)}, 0);
        if (fresh) begin
            run_nr = 0; run_wr = 0; valid_nr = 0; valid_wr = 0;
        end else begin
            if (a_nr) begin
                if (!prev_nr) begin run_nr = 1; valid_nr = 1; end else run_nr++;
            end else if (prev_nr && valid_nr) begin
                check_eq("north_red_run", run_nr, 12);
                valid_nr = 0;
            end
            if (a_wr) begin
                if (!prev_wr) begin run_wr = 1; valid_wr = 1; end else run_wr++;
            end else if (prev_wr && valid_wr) begin
                check_eq("west_red_run", run_wr, 16);
                valid_wr = 0;
            end
        end
        prev_nr = a_nr;
        prev_wr = a_wr;
    endtask

    initial begin
        rst = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1;
            check_eq("a_reset_hold", {a_nr, a_ny, a_ng, a_wr, a_wy, a_wg}, 6'b001_100);
            check_eq("b_reset_hold", {b_nr, b_ny, b_ng, b_wr, b_wy, b_wg}, 6'b001_100);
        end
        @(posedge clk); #1;
        sample(0, 1'b1);
        rst = 1'b0;

        // Three full periods plus the start of WG in the fourth.
        for (int c = 1; c <= 102; c++) begin
            @(posedge clk); #1;
            sample(c, 1'b0);
        end

        // One-cycle reset in the middle of WG.
        rst = 1'b1;
        @(posedge clk); #1;
        sample(0, 1'b1);
        rst = 1'b0;
        for (int c = 1; c <= 56; c++) begin
            @(posedge clk); #1;
            sample(c, 1'b0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule
